// File: rtl/uart_hex_reporter.sv
// Snapshots NUM_CH debug words and streams them as one line of uppercase ASCII hex.
// The line ends in CR LF, and bytes leave through a valid/ready handshake that feeds the uart_tx byte port.
module uart_hex_reporter #(
    parameter int          DATA_W = 16,
    parameter int          NUM_CH = 2,
    parameter int          PERIOD = 27000000,
    parameter logic [7:0]  SEP    = 8'h20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic                     enable,
    input  logic                     trigger,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic                     busy,
    output logic [7:0]               drop_cnt
);
    localparam int ND    = DATA_W / 4;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIG_W = (ND > 1) ? $clog2(ND) : 1;
    localparam int CNT_W = $clog2(PERIOD);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DIG_W-1:0] DIG_TOP  = DIG_W'(ND - 1);
    localparam logic [CH_W-1:0]  CH_TOP   = CH_W'(NUM_CH - 1);

    typedef enum logic [2:0] {IDLE, DIGIT, SEPR, CR, LF} state_t;

    state_t                    state;
    logic [CNT_W-1:0]          cnt;
    logic [CH_W-1:0]           ch;
    logic [DIG_W-1:0]          dig;
    logic [NUM_CH*DATA_W-1:0]  snap;
    logic                      tick;
    logic                      req;
    logic                      xfer;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        if (n < 4'd10)
            return 8'h30 + {4'h0, n};
        else
            return 8'h37 + {4'h0, n};
    endfunction

    function automatic logic [3:0] nibble(input logic [NUM_CH*DATA_W-1:0] w,
                                          input logic [CH_W-1:0]          c,
                                          input logic [DIG_W-1:0]         d);
        return w[int'(c)*DATA_W + int'(d)*4 +: 4];
    endfunction

    assign tick = enable && (cnt == CNT_LAST);
    assign req  = tick || trigger;
    assign xfer = tx_valid && tx_ready;

    // Free-running period counter; keeps running while a frame is in progress.
    always_ff @(posedge clk) begin
        if (rst || !enable)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // tx_data is always loaded with the byte for the state being entered, so it
    // stays stable under backpressure. The snapshot is a data register and is not reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            busy     <= 1'b0;
            drop_cnt <= 8'h00;
            ch       <= '0;
            dig      <= '0;
        end else begin
            if (req && state != IDLE && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            case (state)
                IDLE: begin
                    if (req) begin
                        snap     <= data;
                        busy     <= 1'b1;
                        tx_valid <= 1'b1;
                        ch       <= '0;
                        dig      <= DIG_TOP;
                        tx_data  <= hex_char(nibble(data, '0, DIG_TOP));
                        state    <= DIGIT;
                    end
                end
                DIGIT: begin
                    if (xfer) begin
                        if (dig != '0) begin
                            dig     <= dig - 1'b1;
                            tx_data <= hex_char(nibble(snap, ch, dig - 1'b1));
                        end else if (ch != CH_TOP) begin
                            tx_data <= SEP;
                            state   <= SEPR;
                        end else begin
                            tx_data <= 8'h0D;
                            state   <= CR;
                        end
                    end
                end
                SEPR: begin
                    if (xfer) begin
                        ch      <= ch + 1'b1;
                        dig     <= DIG_TOP;
                        tx_data <= hex_char(nibble(snap, ch + 1'b1, DIG_TOP));
                        state   <= DIGIT;
                    end
                end
                CR: begin
                    if (xfer) begin
                        tx_data <= 8'h0A;
                        state   <= LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        tx_data  <= 8'h00;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_hex_reporter.sv
// Bench for uart_hex_reporter: a 16-bit x 2 channel instance with a byte scoreboard,
// plus an 8-bit x 1 channel instance for the no-separator variant.
module tb_uart_hex_reporter;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, enable, trigger, tx_ready, tx_valid, busy;
    logic [31:0] data;
    logic [7:0]  tx_data, drop_cnt;

    logic        enable2, trigger2, tx_ready2, tx_valid2, busy2;
    logic [7:0]  data2, tx_data2, drop_cnt2;

    uart_hex_reporter #(.DATA_W(16), .NUM_CH(2), .PERIOD(50), .SEP(8'h20)) dut (
        .clk(clk), .rst(rst), .data(data), .enable(enable), .trigger(trigger),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .drop_cnt(drop_cnt));

    uart_hex_reporter #(.DATA_W(8), .NUM_CH(1), .PERIOD(20), .SEP(8'h20)) dut2 (
        .clk(clk), .rst(rst), .data(data2), .enable(enable2), .trigger(trigger2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .busy(busy2), .drop_cnt(drop_cnt2));

    int checks = 0;
    int passes = 0;
    logic [7:0] q[$];

    typedef struct {
        logic [31:0] data;
        int          pct;
        bit          clobber;
        logic [87:0] exp;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s", name);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [87:0] e);
        for (int i = 10; i >= 0; i--) q.push_back(e[i*8 +: 8]);
    endtask

    task automatic drain(input int pct, input int limit, output int n);
        n = 0;
        while (q.size() > 0 && n < limit) begin
            tx_ready = (int'($urandom_range(99)) < pct);
            cyc(1);
            n++;
        end
        if (q.size() > 0) begin
            fail_now("drain timeout");
            q.delete();
        end
        tx_ready = 1'b1;
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        data = v.data;
        push_frame(v.exp);
        trigger = 1'b1;
        cyc(1);
        trigger = 1'b0;
        chk("first valid latency", tx_valid, 1);
        chk("busy after start", busy, 1);
        if (v.clobber) data = 32'h0;
        drain(v.pct, 400, n);
        if (v.pct == 100) chk("frame cycles", n, 11);
        chk("busy after LF", busy, 0);
        chk("valid after LF", tx_valid, 0);
        chk("drop after frame", drop_cnt, 0);
    endtask

    // Scoreboard: a byte leaves on the next edge whenever valid and ready are both high here.
    logic       prev_hold = 1'b0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (prev_hold) chk("hold stable", {tx_valid, tx_data}, {1'b1, prev_data});
        if (!rst && tx_valid && tx_ready) begin
            if (q.size() == 0) fail_now("unexpected byte");
            else chk("frame byte", tx_data, q.pop_front());
        end
        prev_hold = !rst && tx_valid && !tx_ready;
        prev_data = tx_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m, v;
        logic [31:0] b2;
        rst = 1'b1; enable = 1'b0; trigger = 1'b0; tx_ready = 1'b0; data = 32'h0;
        enable2 = 1'b0; trigger2 = 1'b0; tx_ready2 = 1'b1; data2 = 8'h0F;
        cyc(2);
        chk("reset tx_valid", tx_valid, 0);
        chk("reset tx_data", tx_data, 0);
        chk("reset busy", busy, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        tx_ready = 1'b1;
        cyc(2);

        vecs[0] = '{32'hBEEF_1A2F, 100, 1'b0, 88'h31_41_32_46_20_42_45_45_46_0D_0A};
        vecs[1] = '{32'hBEEF_1A2F, 30,  1'b1, 88'h31_41_32_46_20_42_45_45_46_0D_0A};
        vecs[2] = '{32'h0123_89AB, 100, 1'b0, 88'h38_39_41_42_20_30_31_32_33_0D_0A};
        vecs[3] = '{32'hFFFF_0000, 50,  1'b1, 88'h30_30_30_30_20_46_46_46_46_0D_0A};
        for (int i = 0; i < 4; i++) run_vec(vecs[i]);

        // Overrun with the UART stalled
        data = 32'hBEEF_1A2F;
        tx_ready = 1'b0;
        push_frame(vecs[0].exp);
        trigger = 1'b1; cyc(1); trigger = 1'b0; cyc(1);
        repeat (3) begin
            trigger = 1'b1; cyc(1); trigger = 1'b0; cyc(1);
        end
        chk("drop after 3 triggers", drop_cnt, 3);
        chk("first digit held", tx_data, 8'h31);
        trigger = 1'b1; cyc(300); trigger = 1'b0;
        chk("drop saturates", drop_cnt, 255);
        drain(100, 50, n);
        chk("busy after overrun frame", busy, 0);

        // Reset in the middle of a frame
        rst = 1'b1; cyc(1); rst = 1'b0;
        chk("drop cleared", drop_cnt, 0);
        tx_ready = 1'b1;
        push_frame(vecs[0].exp);
        trigger = 1'b1; cyc(1); trigger = 1'b0;
        cyc(4);
        rst = 1'b1; tx_ready = 1'b0;
        cyc(1);
        rst = 1'b0; tx_ready = 1'b1;
        chk("abort tx_valid", tx_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort drop_cnt", drop_cnt, 0);
        chk("bytes sent before abort", q.size(), 7);
        q.delete();
        run_vec(vecs[0]);

        // Periodic starts
        data = 32'hBEEF_1A2F;
        tx_ready = 1'b1;
        rst = 1'b1; enable = 1'b1; cyc(1); rst = 1'b0;
        push_frame(vecs[0].exp);
        push_frame(vecs[0].exp);
        n = 0;
        while (!tx_valid && n < 100) begin cyc(1); n++; end
        chk("first periodic start", n, 50);
        m = 0;
        while (tx_valid && m < 100) begin cyc(1); m++; end
        while (!tx_valid && m < 100) begin cyc(1); m++; end
        chk("periodic interval", m, 50);
        drain(100, 100, n);
        enable = 1'b0;
        v = 0;
        repeat (200) begin cyc(1); if (tx_valid) v++; end
        chk("no frames when disabled", v, 0);
        chk("periodic drop_cnt", drop_cnt, 0);

        // Single 8-bit channel: no separator
        trigger2 = 1'b1; cyc(1); trigger2 = 1'b0;
        b2 = 32'h30_46_0D_0A;
        for (int i = 3; i >= 0; i--) begin
            chk("ch1 valid", tx_valid2, 1);
            chk("ch1 byte", tx_data2, b2[i*8 +: 8]);
            cyc(1);
        end
        chk("ch1 valid after LF", tx_valid2, 0);
        chk("ch1 busy after LF", busy2, 0);

        // Tick and trigger in the same cycle form one request
        rst = 1'b1; enable2 = 1'b1; cyc(1); rst = 1'b0;
        cyc(19);
        trigger2 = 1'b1; cyc(1); trigger2 = 1'b0; enable2 = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            chk("tick+trig byte", tx_data2, b2[i*8 +: 8]);
            cyc(1);
        end
        v = 0;
        repeat (10) begin if (tx_valid2) v++; cyc(1); end
        chk("single frame only", v, 0);
        chk("tick+trig drop_cnt", drop_cnt2, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/uart_hex_reporter.md
Name: uart_hex_reporter

Overview:
Parametrised successor to the single-word UART hex debug dump used on FPGA bring-up tops. It snapshots NUM_CH debug words of DATA_W bits and emits them as one ASCII line of uppercase hex: channels separated by SEP, line terminated by CR LF. Frames start periodically or on a manual trigger. Output is a byte stream with a valid/ready handshake that drives the existing uart_tx byte interface directly. Start requests that arrive while a frame is in progress are counted as overruns.

Parameters:
- DATA_W, 16, bits per channel; must be a multiple of 4; digits per channel ND = DATA_W/4.
- NUM_CH, 2, number of channels; must be at least 1.
- PERIOD, 27000000, clk cycles between periodic frame starts; must be at least 2.
- SEP, 8'h20, separator byte emitted between channels.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- data  in  NUM_CH*DATA_W  channel words; channel c is data[c*DATA_W +: DATA_W].
- enable  in  1  enables periodic frame starts.
- trigger  in  1  single-cycle manual frame-start request.
- tx_data  out  8  byte presented to the UART.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART accepts the byte.
- busy  out  1  a frame is in progress.
- drop_cnt  out  8  saturating count of start requests that were rejected.

Behaviour:
- Reset (rst=1 at a clk edge):
  - tx_valid=0, tx_data=0, busy=0, drop_cnt=0.
  - Period counter=0, state=IDLE.
  - A reset mid-frame aborts the frame. tx_valid drops on the next edge even if no handshake completed.
- Period counter:
  - When enable=1, counts 0..PERIOD-1 and wraps to 0. tick=1 in the cycle where count==PERIOD-1.
  - When enable=0, the counter is held at 0 and tick=0.
- Start request: req = tick OR trigger.
  - trigger is honoured regardless of enable.
  - tick and trigger in the same cycle form one request.
- Handshake:
  - A byte transfers on an edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data must hold stable.
  - tx_valid never deasserts without a transfer, except on reset.
  - After a transfer, the next byte is presented on the following cycle; back-to-back transfers every cycle are allowed.
- States:
  - IDLE:
    - On req, capture all of data into a snapshot register, set busy=1, and go to DIGIT with ch=0, dig=ND-1.
    - tx_valid=1 with the first digit on the next cycle, so latency from req to first tx_valid is 1 cycle.
  - DIGIT:
    - tx_data = hex(snapshot channel ch, nibble dig); 0-9 map to 0x30-0x39, 10-15 map to 0x41-0x46. Digits go MSB first.
    - On transfer: if dig>0, decrement dig. Otherwise, if ch<NUM_CH-1, go to SEP. Otherwise go to CR.
  - SEP: tx_data=SEP. On transfer, increment ch, set dig=ND-1, go to DIGIT.
  - CR: tx_data=0x0D. On transfer, go to LF.
  - LF: tx_data=0x0A. On transfer, go to IDLE; busy=0 and tx_valid=0 from the next cycle.
- Frame length = NUM_CH*ND + (NUM_CH-1) + 2 bytes; 11 bytes at defaults.
- Snapshot:
  - Changes on data after capture do not affect the frame in progress.
  - No separator follows the last channel.
- Overrun:
  - req in any non-IDLE state, including the LF cycle in which the final transfer occurs, is dropped.
  - drop_cnt increments by 1 per such cycle and saturates at 255.
  - The period counter keeps running during frames.
- busy is registered: 1 from the cycle after accepting req through the LF transfer cycle inclusive.

Test Plan:
1. Setup: DATA_W=16, NUM_CH=2, PERIOD=50. data={16'hBEEF, 16'h1A2F} (ch1, ch0), tx_ready=1, pulse trigger -> bytes 31 41 32 46 20 42 45 45 46 0D 0A on 11 consecutive cycles. First tx_valid is 1 cycle after trigger; busy falls after the 0x0A transfer; drop_cnt=0.
2. Backpressure: same setup with tx_ready randomised 30% high, and data changed to 0 after capture -> identical 11-byte sequence; tx_data stable whenever tx_valid=1 and tx_ready=0; no duplicated or skipped bytes.
3. Periodic: enable=1 from reset release, tx_ready=1 -> first tx_valid at cycle 50 after reset release, then frames every 50 cycles. With enable=0 for 200 cycles -> no frames.
4. Overrun: tx_ready=0, trigger, then 3 further triggers -> drop_cnt=3 and frame content unchanged. Holding trigger high for 300 cycles while busy -> drop_cnt=255, no wrap.
5. Reset mid-frame: rst for 1 cycle after the 4th transfer -> tx_valid=0, busy=0, drop_cnt=0 on the next cycle. The next trigger restarts at 0x31 and the full frame follows.
6. Parameter variant: DATA_W=8, NUM_CH=1, data=8'h0F, trigger -> bytes 30 46 0D 0A with no separator. Simultaneous tick and trigger in IDLE -> one frame, drop_cnt stays 0.
